// File: rtl/class_gen.sv
// class_gen: scans 4-bit codes START_VAL..15 and emits those in the class chosen by sel.
// Optional feature macro CLASS_GEN_COUNT_EN adds the saturating match_count counter.
module class_gen #(
    parameter int unsigned START_VAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sel,
    output logic [3:0] out_val,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] match_count
);

    // Out-of-range start values fall back to 1 so code 0 can never be scanned.
    localparam logic [3:0] StartVal = (START_VAL >= 1 && START_VAL <= 15) ?
                                      4'(START_VAL) : 4'd1;

    typedef enum logic [1:0] {StIdle, StScan, StHold, StDone} state_e;

    state_e     state;
    logic [3:0] cand;
    logic [1:0] sel_q;
    logic       mult3;
    logic       even;
    logic       hit;

    always_comb begin
        mult3 = (cand == 4'd3) || (cand == 4'd6) || (cand == 4'd9) ||
                (cand == 4'd12) || (cand == 4'd15);
        even  = (cand != 4'd0) && !cand[0];
        hit   = 1'b0;
        case (sel_q)
            2'b00:   hit = mult3;
            2'b01:   hit = even;
            2'b10:   hit = mult3 && even;
            default: hit = (cand != 4'd0) && cand[0] && !mult3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cand      <= StartVal;
            sel_q     <= 2'b00;
            out_val   <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        sel_q <= sel;
                        cand  <= StartVal;
                        busy  <= 1'b1;
                        state <= StScan;
                    end
                end
                StScan: begin
                    if (hit) begin
                        out_val   <= cand;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end else if (cand == 4'd15) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        cand <= cand + 4'd1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cand == 4'd15) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            cand  <= cand + 4'd1;
                            state <= StScan;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CLASS_GEN_COUNT_EN
    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (state == StIdle && start) begin
            count_q <= 4'd0;
        end else if (state == StHold && out_ready && count_q != 4'd15) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign match_count = count_q;
`else
    assign match_count = 4'd0;
`endif

endmodule

// File: tb/tb_class_gen.sv
// Directed self-checking bench for class_gen: full scans per class, backpressure,
// reset abort and ignored start/sel during a scan.
module tb_class_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [3:0] out_val;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [3:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    class_gen #(.START_VAL(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sel        (sel),
        .out_val    (out_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .match_count(match_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_count(input int n);
`ifdef CLASS_GEN_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Starts a scan at the current negedge with out_ready=1 and collects transferred codes,
    // packed 4 bits per code, oldest in the most significant position.
    task automatic run_scan(input string tag, input logic [1:0] s, input logic [63:0] exp_codes,
                            input int exp_n, input int exp_first, input bit disturb);
        logic [63:0] acc;
        int          n;
        int          first;
        int          dones;
        int          max_cnt;
        bit          zero_seen;
        bit          finished;
        acc = '0; n = 0; first = -1; dones = 0; max_cnt = 0; zero_seen = 0; finished = 0;
        sel = s; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if (int'(match_count) > max_cnt) max_cnt = int'(match_count);
            if (out_valid) begin
                if (first < 0) first = i;
                if (out_val == 4'd0) zero_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                acc = {acc[59:0], out_val};
                n++;
            end
            if (done) begin
                dones++;
                finished = 1'b1;
            end
            if (disturb && i == 2) begin
                start = 1'b1;
                sel   = ~s;
            end
            if (disturb && i == 3) start = 1'b0;
            @(negedge clk);
        end
        check_eq({tag, ".codes"}, acc, exp_codes);
        check_eq({tag, ".ncodes"}, 64'(n), 64'(exp_n));
        check_eq({tag, ".first_valid"}, 64'(first), 64'(exp_first));
        check_eq({tag, ".done_pulses"}, 64'(dones), 64'd1);
        check_eq({tag, ".zero_code"}, 64'(zero_seen), 64'd0);
        check_eq({tag, ".match_count"}, 64'(match_count), 64'(exp_count(exp_n)));
        check_eq({tag, ".max_count"}, 64'(max_cnt), 64'(exp_count(exp_n)));
        check_eq({tag, ".idle_busy"}, 64'(busy), 64'd0);
        check_eq({tag, ".idle_done"}, 64'(done), 64'd0);
        @(negedge clk);
        check_eq({tag, ".no_requeue"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit found;
        bit stable;

        // Reset with start held high: reset wins and start must not be queued.
        rst = 1'b1; start = 1'b1; sel = 2'b10; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst.out_val", 64'(out_val), 64'd0);
        check_eq("rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.match_count", 64'(match_count), 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("rst.start_ignored", 64'(busy), 64'd0);

        run_scan("mult3", 2'b00, 64'h369CF, 5, 3, 1'b0);
        run_scan("even", 2'b01, 64'h2468ACE, 7, 2, 1'b0);
        run_scan("both", 2'b10, 64'h6C, 2, 6, 1'b0);
        run_scan("neither", 2'b11, 64'h157BD, 5, 1, 1'b0);
        run_scan("disturb", 2'b00, 64'h369CF, 5, 3, 1'b1);

        // Backpressure: first match held for 5 cycles.
        sel = 2'b00; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("hold.found", 64'(found), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid && out_val == 4'd3 && busy)) stable = 1'b0;
            @(negedge clk);
        end
        check_eq("hold.stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("hold.valid_drop", 64'(out_valid), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("hold.next_code", 64'(found ? out_val : 4'd0), 64'd6);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("hold.done", 64'(found), 64'd1);
        @(negedge clk);

        // Abort in HOLD with out_val=4, start asserted alongside rst.
        sel = 2'b01; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid && out_val == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("abort.reach_hold4", 64'(found), 64'd1);
        rst = 1'b1; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("abort.out_valid", 64'(out_valid), 64'd0);
        check_eq("abort.out_val", 64'(out_val), 64'd0);
        check_eq("abort.busy", 64'(busy), 64'd0);
        check_eq("abort.done", 64'(done), 64'd0);
        check_eq("abort.match_count", 64'(match_count), 64'd0);
        run_scan("after_abort", 2'b01, 64'h2468ACE, 7, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/class_gen.md
CLASS_GEN -- requirements
Module: class_gen

Interface
REQ-001 The block SHALL have one parameter: START_VAL, default 1, first candidate scanned (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset; the block SHALL sample it on the rising edge of clk.
REQ-004 Port: start  input  1  single-cycle request to begin a scan; SHALL be honoured only in IDLE.
REQ-005 Port: sel  input  2  class select: 00 = nonzero multiple of 3, 01 = nonzero even, 10 = both, 11 = neither (nonzero, odd, not a multiple of 3).
REQ-006 Port: out_val  output  4  emitted 4-bit code.
REQ-007 Port: out_valid  output  1  out_val holds a matching code.
REQ-008 Port: out_ready  input  1  consumer accepts out_val; a transfer SHALL occur on a cycle where out_valid and out_ready are both 1.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  single-cycle pulse at scan end.
REQ-011 Port: match_count  output  4  number of codes transferred in the current or last scan.

Function
REQ-012 The FSM SHALL have four states: IDLE, SCAN, HOLD and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch sel into sel_q, load cand=START_VAL, clear match_count and enter SCAN on the next cycle.
REQ-014 In SCAN, the block SHALL evaluate one candidate per cycle using sel_q; a change to sel after start SHALL have no effect on the scan.
REQ-015 In SCAN, a matching cand SHALL cause entry to HOLD, with out_val=cand and out_valid=1 from the next cycle.
REQ-016 In SCAN, a non-matching cand SHALL cause entry to DONE if cand=15, and otherwise an increment of cand with the block remaining in SCAN.
REQ-017 In HOLD, out_val and out_valid SHALL stay stable while out_ready=0.
REQ-018 In HOLD, on transfer the block SHALL drop out_valid next cycle, increment match_count, and go to DONE if cand=15, else increment cand and go to SCAN.
REQ-019 cand SHALL never wrap from 15 to 0; code 0 SHALL never be emitted.
REQ-020 DONE SHALL last exactly one cycle, assert done=1 during it, and then return to IDLE.
REQ-021 start asserted in SCAN, HOLD or DONE SHALL be ignored and SHALL NOT be queued.
REQ-022 start asserted in the same cycle as rst SHALL be ignored; rst SHALL take priority.
REQ-023 Minimum latency SHALL be: start at cycle n, first candidate evaluated at n+1, earliest out_valid at n+2.
REQ-024 The match predicates SHALL be purely combinational on cand:
- mult3 = cand in {3,6,9,12,15}
- even = cand in {2,4,...,14}
REQ-025 A START_VAL outside 1..15 SHALL be treated as 1.

Reset
REQ-026 On rst, the block SHALL enter IDLE.
REQ-027 On rst, the outputs SHALL be: out_val=0, out_valid=0, busy=0, done=0, match_count=0.
REQ-028 On rst, the internal registers SHALL be: cand=START_VAL, sel_q=00.
REQ-029 An rst in any state, including HOLD with out_valid=1, SHALL abort the scan in the same edge with no done pulse.
REQ-030 After an abort by rst, the next cycle SHALL accept start.

Configuration
REQ-031 The feature macro SHALL be CLASS_GEN_COUNT_EN.
REQ-032 With CLASS_GEN_COUNT_EN defined, match_count SHALL behave as in REQ-011, REQ-013 and REQ-018 (saturating at 15).
REQ-033 Without CLASS_GEN_COUNT_EN, match_count SHALL remain a port tied to constant 0 and the counter SHALL NOT be synthesized.
REQ-034 All other behaviour SHALL be identical with and without CLASS_GEN_COUNT_EN.

Verification
REQ-035 Scenario: sel=00, START_VAL=1, out_ready=1 -> emits 3,6,9,12,15 in order; done pulses once; match_count=5.
REQ-036 Scenario: sel=01, out_ready=1 -> emits 2,4,6,8,10,12,14; match_count=7; no code 0 emitted.
REQ-037 Scenario: sel=10 -> emits 6 and 12 only; sel=11 -> emits 1,5,7,11,13 only.
REQ-038 Scenario: sel=00, out_ready held 0 for 5 cycles at first match -> out_val=3 and out_valid=1 stable for those 5 cycles; out_ready=1 -> next emitted code is 6.
REQ-039 Scenario: sel=01, rst pulsed while HOLD with out_val=4 -> next cycle out_valid=0, busy=0, match_count=0, no done; a new start runs a full scan correctly.
REQ-040 Scenario: start re-pulsed mid-scan and sel changed mid-scan -> output sequence unchanged; with CLASS_GEN_COUNT_EN undefined, match_count=0 throughout.
